// File: rtl/branch_seq_control_unit_if.sv
// branch_seq_control_unit_if: instruction/flag inputs and datapath control strobes of the sequencer.
interface branch_seq_control_unit_if;
    logic [31:0] IR;
    logic        CON_out;
    logic        PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, IncPC;
    logic        PC_out, Zlow_out, MDR_out, C_out;
    logic        Read, Write;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        CON_in;
    logic [4:0]  alu_instruction_bits;
    logic        Run;
    modport master (
        output IR, CON_out,
        input  PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, IncPC,
        input  PC_out, Zlow_out, MDR_out, C_out, Read, Write,
        input  Gra, Grb, Grc, Rin, Rout, BAout, CON_in, alu_instruction_bits, Run
    );
    modport slave (
        input  IR, CON_out,
        output PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, IncPC,
        output PC_out, Zlow_out, MDR_out, C_out, Read, Write,
        output Gra, Grb, Grc, Rin, Rout, BAout, CON_in, alu_instruction_bits, Run
    );
endinterface

// File: rtl/branch_seq_control_unit.sv
// branch_seq_control_unit: Moore fetch/decode/execute sequencer; each instruction class gets its own state chain.
module branch_seq_control_unit (
    input  logic                      clk,
    input  logic                      clr,
    branch_seq_control_unit_if.slave  bus
);
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    typedef enum logic [4:0] {
        T0, T1, T2, T3, R4, R5, I4, I5, L4, L5, L6, L7, S4, S5, S6, S7, B4, B5, B6, HALT
    } state_t;
    state_t      r_state, w_next;
    logic [4:0]  r_alu;
    logic [4:0]  w_op;
    logic        w_is_r;
    logic        w_unused;
    assign w_op     = bus.IR[31:27];
    assign w_is_r   = w_op inside {[5'b00011:5'b00110]};
    assign w_unused = &{1'b0, bus.IR[26:0]};
    // The R-type ALU code is captured at decode so later IR changes cannot alter it.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= T0;
            r_alu   <= 5'd0;
        end else begin
            r_state <= w_next;
            if (r_state == T3) r_alu <= w_op;
        end
    end
    always_comb begin
        w_next = T0;
        case (r_state)
            T0:      w_next = T1;
            T1:      w_next = T2;
            T2:      w_next = T3;
            T3:      w_next = w_is_r ? R4 : (w_op == OP_ADDI) ? I4 : (w_op == OP_LD) ? L4 :
                              (w_op == OP_ST) ? S4 : (w_op == OP_BR) ? B4 : (w_op == OP_HALT) ? HALT : T0;
            R4:      w_next = R5;
            I4:      w_next = I5;
            L4:      w_next = L5;
            L5:      w_next = L6;
            L6:      w_next = L7;
            S4:      w_next = S5;
            S5:      w_next = S6;
            S6:      w_next = S7;
            B4:      w_next = B5;
            B5:      w_next = B6;
            HALT:    w_next = HALT;
            default: w_next = T0;
        endcase
    end
    // Reset gates every strobe off combinationally so nothing fires while clr is held.
    always_comb begin
        bus.PC_in = 1'b0;
        bus.IR_in = 1'b0;
        bus.Y_in = 1'b0;
        bus.Z_in = 1'b0;
        bus.MAR_in = 1'b0;
        bus.MDR_in = 1'b0;
        bus.IncPC = 1'b0;
        bus.PC_out = 1'b0;
        bus.Zlow_out = 1'b0;
        bus.MDR_out = 1'b0;
        bus.C_out = 1'b0;
        bus.Read = 1'b0;
        bus.Write = 1'b0;
        bus.Gra = 1'b0;
        bus.Grb = 1'b0;
        bus.Grc = 1'b0;
        bus.Rin = 1'b0;
        bus.Rout = 1'b0;
        bus.BAout = 1'b0;
        bus.CON_in = 1'b0;
        bus.alu_instruction_bits = 5'd0;
        bus.Run = clr || (r_state != HALT);
        if (!clr) begin
            case (r_state)
                T0: begin bus.PC_out = 1'b1; bus.MAR_in = 1'b1; bus.IncPC = 1'b1; bus.Z_in = 1'b1; end
                T1: begin bus.Zlow_out = 1'b1; bus.PC_in = 1'b1; bus.Read = 1'b1; bus.MDR_in = 1'b1; end
                T2: begin bus.MDR_out = 1'b1; bus.IR_in = 1'b1; end
                T3: begin
                    if (w_is_r || w_op == OP_ADDI) begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1;
                    end else if (w_op == OP_LD || w_op == OP_ST) begin
                        bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_in = 1'b1;
                    end else if (w_op == OP_BR) begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CON_in = 1'b1;
                    end
                end
                R4: begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Z_in = 1'b1; bus.alu_instruction_bits = r_alu; end
                I4, L4, S4, B5: begin bus.C_out = 1'b1; bus.Z_in = 1'b1; bus.alu_instruction_bits = ALU_ADD; end
                R5, I5: begin bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                L5, S5: begin bus.Zlow_out = 1'b1; bus.MAR_in = 1'b1; end
                L6: begin bus.Read = 1'b1; bus.MDR_in = 1'b1; end
                L7: begin bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                S6: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDR_in = 1'b1; end
                S7: bus.Write = 1'b1;
                B4: begin bus.PC_out = 1'b1; bus.Y_in = 1'b1; end
                B6: begin bus.Zlow_out = bus.CON_out; bus.PC_in = bus.CON_out; end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/branch_seq_control_unit.md
BRANCH_SEQ_CONTROL_UNIT -- requirements
Module: branch_seq_control_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are named clk and clr as elsewhere in the codebase.
REQ-002 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 clr  input  1  synchronous active-high reset.
REQ-004 IR  input  32  instruction register contents; opcode = IR[31:27].
REQ-005 CON_out  input  1  branch-condition flag from the CON FF logic.
REQ-006 PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, IncPC  output  1 each  datapath register load enables.
REQ-007 PC_out, Zlow_out, MDR_out, C_out  output  1 each  datapath bus drive enables.
REQ-008 Read, Write  output  1 each  memory strobes.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  select-and-encode controls.
REQ-010 CON_in  output  1  load enable for the CON FF.
REQ-011 alu_instruction_bits  output  5  ALU operation code.
REQ-012 Run  output  1  1 = executing, 0 = halted.

Function
REQ-013 SHALL be a Moore FSM; every output is decoded from the present state only and is held for exactly one clk cycle per state.
REQ-014 Per-state outputs not listed SHALL be 0; alu_instruction_bits SHALL be 0 except where listed.
REQ-015 T0: PC_out, MAR_in, IncPC, Z_in. T1: Zlow_out, PC_in, Read, MDR_in. T2: MDR_out, IR_in. Then T3.
REQ-016 Decode SHALL occur in T3 using IR (valid after the T2 edge); the branch taken is fixed for the rest of the instruction.
REQ-017 R-type (opcodes 00011 add, 00100 sub, 00101 and, 00110 or) SHALL run: T3 Grb,Rout,Y_in. T4 Grc,Rout,Z_in, alu_instruction_bits=opcode. T5 Zlow_out,Gra,Rin. Then T0 (6 cycles total).
REQ-018 addi (01100) SHALL run: T3 Grb,Rout,Y_in. T4 C_out,Z_in, alu=00011. T5 Zlow_out,Gra,Rin. Then T0.
REQ-019 ld (00000) SHALL run: T3 Grb,BAout,Y_in. T4 C_out,Z_in, alu=00011. T5 Zlow_out,MAR_in. T6 Read,MDR_in. T7 MDR_out,Gra,Rin. Then T0 (8 cycles).
REQ-020 st (00010) SHALL run: T3-T5 as ld. T6 Gra,Rout,MDR_in with Read=0. T7 Write. Then T0.
REQ-021 br (10010) SHALL run: T3 Gra,Rout,CON_in. T4 PC_out,Y_in. T5 C_out,Z_in, alu=00011. T6: Zlow_out,PC_in only if CON_out=1; otherwise all outputs 0. Then T0 (7 cycles either way).
REQ-022 CON_out SHALL be sampled during T6 only; CON_out changes in any other state SHALL have no effect.
REQ-023 nop (11010) and every unlisted opcode SHALL spend T3 with all outputs 0, then T0 (4 cycles).
REQ-024 halt (11011) SHALL enter state HALT from T3: all outputs 0, Run=0, and it remains there until clr.
REQ-025 Run SHALL be 1 in every state except HALT.
REQ-026 At most one of PC_out, Zlow_out, MDR_out, C_out, Rout and BAout SHALL be 1 in any cycle.
REQ-027 Read and Write SHALL never be 1 in the same cycle.

Reset
REQ-028 clr=1 at a posedge SHALL force state T0 on that edge; clr overrides every other condition, including a transition out of HALT.
REQ-029 While clr=1, every output SHALL be 0 except Run, which SHALL be 1. The first cycle after clr deasserts SHALL be T0 with T0 outputs active.
REQ-030 clr asserted in the middle of an instruction (for example in ld T6) SHALL abort it with no further strobes, and fetch SHALL restart at T0.

Verification
REQ-031 add: IR=opcode 00011. Expect T3 Grb+Rout+Y_in, T4 Grc+Rout+Z_in with alu=00011, T5 Zlow_out+Gra+Rin, and T0 again at cycle 7.
REQ-032 brpl false: IR=opcode 10010, CON_out=0 in T6. Expect T5 C_out with alu=00011, T6 all outputs 0 with PC_in=0, and T0 on the next cycle.
REQ-033 br true: same IR, CON_out=1 in T6 and toggled to 0 in T4. Expect T6 Zlow_out=1 and PC_in=1.
REQ-034 ld then st back-to-back: expect Read in T1 and T6 of ld, Write only in T7 of st, and Read=Write=1 in no cycle.
REQ-035 halt: IR=opcode 11011. Expect Run=0 from the cycle after T3 and held for 20+ cycles with all outputs 0. Assert clr: expect Run=1 and T0 on the cycle after clr deasserts.
REQ-036 Mid-ld reset: assert clr during T6. Expect all outputs 0 on the next edge, no T7 MDR_out, and a restart at T0.
